// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and slot record for the register-file write arbiter.
// The slot fields are sized by RF_DATA_W/RF_ADDR_W; the top's DATA_W/ADDR_W must match them.
package regfile_arb_pkg;

    localparam int RF_DATA_W  = 32;
    localparam int RF_ADDR_W  = 5;
    localparam int RF_NUM_REQ = 2;
    localparam int RF_PTR_W   = $clog2(RF_NUM_REQ);

    typedef struct packed {
        logic                 full;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } slot_t;

    // Round-robin successor of index i among n requesters.
    function automatic int rr_next(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side and write-port signals of the register-file write arbiter.
// Handshake: a request transfers at a rising edge where ReqValid[i] and ReqReady[i] are both 1;
// ReqReady never depends on ReqValid, and Grant/WrEnable/WrAddr/WrData are outputs only.
interface regfile_write_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = RF_NUM_REQ,
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W
);

    logic [NUM_REQ-1:0]        ReqValid;
    logic [NUM_REQ-1:0]        ReqReady;
    logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
    logic [NUM_REQ*DATA_W-1:0] ReqData;
    logic                      WrEnable;
    logic [ADDR_W-1:0]         WrAddr;
    logic [DATA_W-1:0]         WrData;
    logic [NUM_REQ-1:0]        Grant;
    logic                      Busy;

    modport master (
        output ReqValid, ReqAddr, ReqData,
        input  ReqReady, WrEnable, WrAddr, WrData, Grant, Busy
    );

    modport slave (
        input  ReqValid, ReqAddr, ReqData,
        output ReqReady, WrEnable, WrAddr, WrData, Grant, Busy
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// NUM_REQ-way round-robin grant: first requesting index at or after ptr, wrapping.
// Every index used is a loop constant, so the search unrolls into a flat priority mux.
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = RF_NUM_REQ,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   next_ptr
);

    logic found;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        // Offset k outer loop gives priority to the index closest to ptr.
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (ptr == PTR_W'((j - k + NUM_REQ) % NUM_REQ))) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    next_ptr = PTR_W'(rr_next(j, NUM_REQ));
                end
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares one registered register-file write port among NUM_REQ writeback requesters,
// each with a one-entry holding slot. Optional ZERO_REG_DROP_EN swallows writes to index 0.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int NUM_REQ = RF_NUM_REQ
) (
    input  logic                   Clock,
    input  logic                   Reset,
    regfile_write_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    slot_t              slot_q [NUM_REQ];
    slot_t              slot_d [NUM_REQ];
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic               wr_en_q;
    logic               wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q;
    logic [DATA_W-1:0]  wr_data_d;

    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] fill;

    always_comb begin
        full = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            full[i] = slot_q[i].full;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req      (full),
        .ptr      (ptr_q),
        .grant    (grant),
        .next_ptr (ptr_d)
    );

    // A draining slot can take a new request in the same cycle.
    assign ready = ~full | grant;

    always_comb begin
        fill = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fill[i] = bus.ReqValid[i] & ready[i];
`ifdef ZERO_REG_DROP_EN
            // Index 0 completes the handshake but never occupies the slot.
            if (bus.ReqAddr[i*ADDR_W +: ADDR_W] == '0) begin
                fill[i] = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_d[i] = slot_q[i];
            if (grant[i]) begin
                slot_d[i].full = 1'b0;
            end
            if (fill[i]) begin
                slot_d[i].full = 1'b1;
                slot_d[i].addr = bus.ReqAddr[i*ADDR_W +: ADDR_W];
                slot_d[i].data = bus.ReqData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        wr_en_d   = |grant;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                wr_addr_d = slot_q[i].addr;
                wr_data_d = slot_q[i].data;
            end
        end
    end

    // Reset wins over any accept, so requests seen while Reset=0 are dropped.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_q[i] <= '0;
            end
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_q[i] <= slot_d[i];
            end
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.ReqReady = ready;
    assign bus.Grant    = grant;
    assign bus.WrEnable = wr_en_q;
    assign bus.WrAddr   = wr_addr_q;
    assign bus.WrData   = wr_data_q;
    assign bus.Busy     = (|full) | wr_en_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; honours ZERO_REG_DROP_EN when defined.
module tb_regfile_write_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] exp_d;

    regfile_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REQ(NR)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.ReqAddr[idx*AW +: AW] = addr;
        bus.ReqData[idx*DW +: DW] = data;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.ReqValid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.ReqValid = 2'b11;
        set_req(0, 5'd3, 32'hAAAA_0001);
        set_req(1, 5'd4, 32'hBBBB_0002);
        tick();
        tick();
        tick();
        n_cmp++;
        if (bus.WrEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wren_in_reset: got %0b expected 0", bus.WrEnable);
        end
        rst_n        = 1'b1;
        bus.ReqValid = '0;
        n_cmp++;
        if (bus.WrEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wren: got %0b expected 0", bus.WrEnable);
        end
        n_cmp++;
        if (bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %0b expected 0", bus.Busy);
        end
        n_cmp++;
        if (bus.ReqReady !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 11", bus.ReqReady);
        end
        n_cmp++;
        if (bus.Grant !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_grant: got %b expected 00", bus.Grant);
        end
        n_cmp++;
        if (bus.WrAddr !== 5'd0 || bus.WrData !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_wr_bus: got %0d/%h expected 0/00000000", bus.WrAddr, bus.WrData);
        end
        tick();
        n_cmp++;
        if (bus.Busy !== 1'b0 || bus.WrEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_accept: got busy=%0b wren=%0b expected 0/0", bus.Busy, bus.WrEnable);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.ReqValid = 2'b01;
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        set_req(1, 5'd9, 32'h1234_5678);
        tick();
        bus.ReqValid = '0;
        n_cmp++;
        if (bus.Grant !== 2'b01 || bus.WrEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c1: got grant=%b wren=%0b expected 01/0", bus.Grant, bus.WrEnable);
        end
        n_cmp++;
        if (bus.Busy !== 1'b1 || bus.ReqReady !== 2'b11) begin
            n_fail++;
            $display("FAIL single_c1_busy_ready: got %0b/%b expected 1/11", bus.Busy, bus.ReqReady);
        end
        tick();
        n_cmp++;
        if (bus.WrEnable !== 1'b1 || bus.WrAddr !== 5'd5 || bus.WrData !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_c2_write: got %0b/%0d/%h expected 1/5/deadbeef",
                     bus.WrEnable, bus.WrAddr, bus.WrData);
        end
        n_cmp++;
        if (bus.Grant !== 2'b00) begin
            n_fail++;
            $display("FAIL single_c2_grant: got %b expected 00", bus.Grant);
        end
        tick();
        n_cmp++;
        if (bus.WrEnable !== 1'b0 || bus.Busy !== 1'b0 || bus.WrAddr !== 5'd5) begin
            n_fail++;
            $display("FAIL single_c3: got wren=%0b busy=%0b addr=%0d expected 0/0/5",
                     bus.WrEnable, bus.Busy, bus.WrAddr);
        end
    endtask

    task automatic test_lone_throughput();
        logic [1:0] g_exp;
        logic       w_exp;
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            g_exp = (c >= 1 && c <= 5) ? 2'b10 : 2'b00;
            w_exp = (c >= 2 && c <= 6);
            n_cmp++;
            if (bus.ReqReady !== 2'b11 || bus.Grant !== g_exp) begin
                n_fail++;
                $display("FAIL lone_c%0d_ready_grant: got %b/%b expected 11/%b", c, bus.ReqReady, bus.Grant, g_exp);
            end
            n_cmp++;
            if (bus.WrEnable !== w_exp) begin
                n_fail++;
                $display("FAIL lone_c%0d_wren: got %0b expected %0b", c, bus.WrEnable, w_exp);
            end
            if (w_exp) begin
                n_cmp++;
                if (bus.WrAddr !== AW'(c + 1) || bus.WrData !== 32'h3000_0000 + DW'(c - 2)) begin
                    n_fail++;
                    $display("FAIL lone_c%0d_write: got %0d/%h expected %0d/%h", c, bus.WrAddr, bus.WrData,
                             c + 1, 32'h3000_0000 + DW'(c - 2));
                end
            end
            bus.ReqValid = (c < 5) ? 2'b10 : 2'b00;
            set_req(1, AW'(c + 3), 32'h3000_0000 + DW'(c));
            tick();
        end
        bus.ReqValid = '0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] g_exp;
        logic [1:0] r_exp;
        logic       w_exp;
        do_reset();
        exp_q0.delete();
        exp_q1.delete();
        for (int c = 0; c <= 13; c++) begin
            g_exp = (c >= 1 && c <= 11) ? ((c % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
            r_exp = (c >= 1 && c <= 10) ? g_exp : 2'b11;
            w_exp = (c >= 2 && c <= 12);
            n_cmp++;
            if (bus.Grant !== g_exp || bus.ReqReady !== r_exp) begin
                n_fail++;
                $display("FAIL b2b_c%0d_grant_ready: got %b/%b expected %b/%b", c, bus.Grant, bus.ReqReady, g_exp, r_exp);
            end
            n_cmp++;
            if (bus.WrEnable !== w_exp) begin
                n_fail++;
                $display("FAIL b2b_c%0d_wren: got %0b expected %0b", c, bus.WrEnable, w_exp);
            end
            if (w_exp) begin
                n_cmp++;
                if (c % 2 == 0) begin
                    exp_d = (exp_q0.size() > 0) ? exp_q0.pop_front() : 32'hXXXX_XXXX;
                    if (bus.WrAddr !== 5'd1 || bus.WrData !== exp_d) begin
                        n_fail++;
                        $display("FAIL b2b_c%0d_write0: got %0d/%h expected 1/%h", c, bus.WrAddr, bus.WrData, exp_d);
                    end
                end else begin
                    exp_d = (exp_q1.size() > 0) ? exp_q1.pop_front() : 32'hXXXX_XXXX;
                    if (bus.WrAddr !== 5'd2 || bus.WrData !== exp_d) begin
                        n_fail++;
                        $display("FAIL b2b_c%0d_write1: got %0d/%h expected 2/%h", c, bus.WrAddr, bus.WrData, exp_d);
                    end
                end
            end
            if (c < 10) begin
                bus.ReqValid = 2'b11;
                set_req(0, 5'd1, 32'h1000_0000 + DW'(c));
                set_req(1, 5'd2, 32'h2000_0000 + DW'(c));
                if (r_exp[0]) exp_q0.push_back(32'h1000_0000 + DW'(c));
                if (r_exp[1]) exp_q1.push_back(32'h2000_0000 + DW'(c));
            end else begin
                bus.ReqValid = '0;
            end
            tick();
        end
        n_cmp++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_leftover: got %0d/%0d queued expected 0/0", exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic test_same_addr_order();
        logic w_exp;
        int   n_wr;
        do_reset();
        exp_q0.delete();
        n_wr = 0;
        bus.ReqValid = 2'b10;
        set_req(1, 5'd7, 32'h0000_0022);
        exp_q0.push_back(32'h0000_0022);
        tick();
        n_cmp++;
        if (bus.Grant !== 2'b10) begin
            n_fail++;
            $display("FAIL order_c1_grant: got %b expected 10", bus.Grant);
        end
        bus.ReqValid = 2'b01;
        set_req(0, 5'd7, 32'h0000_0011);
        exp_q0.push_back(32'h0000_0011);
        tick();
        bus.ReqValid = '0;
        for (int c = 2; c <= 5; c++) begin
            w_exp = (c <= 3);
            n_cmp++;
            if (bus.WrEnable !== w_exp) begin
                n_fail++;
                $display("FAIL order_c%0d_wren: got %0b expected %0b", c, bus.WrEnable, w_exp);
            end
            if (bus.WrEnable === 1'b1) begin
                n_wr++;
                exp_d = (exp_q0.size() > 0) ? exp_q0.pop_front() : 32'hXXXX_XXXX;
                n_cmp++;
                if (bus.WrAddr !== 5'd7 || bus.WrData !== exp_d) begin
                    n_fail++;
                    $display("FAIL order_c%0d_write: got %0d/%h expected 7/%h", c, bus.WrAddr, bus.WrData, exp_d);
                end
            end
            tick();
        end
        n_cmp++;
        if (n_wr != 2 || exp_q0.size() != 0) begin
            n_fail++;
            $display("FAIL order_count: got %0d writes expected 2", n_wr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.ReqValid = 2'b11;
        set_req(0, 5'd9, 32'h0000_0909);
        set_req(1, 5'd10, 32'h0000_0A0A);
        tick();
        bus.ReqValid = '0;
        rst_n        = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (bus.Busy !== 1'b0 || bus.Grant !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_busy_grant: got %0b/%b expected 0/00", bus.Busy, bus.Grant);
        end
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (bus.WrEnable !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_wren_%0d: got %0b expected 0", c, bus.WrEnable);
            end
            tick();
        end
    endtask

    task automatic test_zero_addr();
        do_reset();
        bus.ReqValid = 2'b01;
        set_req(0, 5'd0, 32'hFFFF_FFFF);
        n_cmp++;
        if (bus.ReqReady[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: got %0b expected 1", bus.ReqReady[0]);
        end
        tick();
        bus.ReqValid = '0;
`ifdef ZERO_REG_DROP_EN
        n_cmp++;
        if (bus.Grant !== 2'b00 || bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_drop_c1: got grant=%b busy=%0b expected 00/0", bus.Grant, bus.Busy);
        end
        tick();
        n_cmp++;
        if (bus.WrEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_drop_c2: got wren=%0b expected 0", bus.WrEnable);
        end
`else
        n_cmp++;
        if (bus.Grant !== 2'b01) begin
            n_fail++;
            $display("FAIL zero_keep_c1: got grant=%b expected 01", bus.Grant);
        end
        tick();
        n_cmp++;
        if (bus.WrEnable !== 1'b1 || bus.WrAddr !== 5'd0 || bus.WrData !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL zero_keep_c2: got %0b/%0d/%h expected 1/0/ffffffff", bus.WrEnable, bus.WrAddr, bus.WrData);
        end
`endif
        tick();
        n_cmp++;
        if (bus.WrEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_c3_wren: got %0b expected 0", bus.WrEnable);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.ReqValid = '0;
        bus.ReqAddr  = '0;
        bus.ReqData  = '0;
        test_reset();
        test_single();
        test_lone_throughput();
        test_back_to_back();
        test_same_addr_order();
        test_reset_mid();
        test_zero_addr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
